// File: rtl/prio_pkg.sv
// Shared constants and helpers for the prio_enc_rr family.
// Contents:
//   clog2      - constant ceil(log2(v)), never less than 1
//   MODE_FIXED - mode input value selecting fixed priority
//   MODE_RR    - mode input value selecting round-robin
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for a vector of v entries; a 1-bit index is the minimum.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_enc_fixed.sv
// Combinational fixed-priority encoder: the highest set bit wins.
// Ports:
//   req     [N-1:0]  request vector
//   idx_c   [W-1:0]  index of the highest set bit (0 when no bit is set)
//   hit_c            at least one bit set
//   multi_c          more than one bit set
module prio_enc_fixed
  import prio_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]          req,
  output logic [clog2(N)-1:0]   idx_c,
  output logic                  hit_c,
  output logic                  multi_c
);

  localparam int unsigned W = clog2(N);

  // Ascending scan, so the last (highest) set bit overwrites earlier ones.
  always_comb begin
    idx_c = '0;
    hit_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx_c = W'(i);
        hit_c = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c = |(req & (req - N'(1)));

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with selectable fixed / round-robin arbitration.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   mode        0 = fixed priority, 1 = round-robin
//   req [N-1:0] request vector, sampled on capture edges
//   out_ready   downstream accepts the current output
//   out_valid   output register holds a grant
//   out_idx     granted index (W = clog2(N) bits)
//   out_onehot  one-hot form of out_idx, zero when out_valid = 0
//   out_multi   more than one request bit was set at capture
module prio_enc_rr
  import prio_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [N-1:0]          req,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [clog2(N)-1:0]   out_idx,
  output logic [N-1:0]          out_onehot,
  output logic                  out_multi
);

  localparam int unsigned W  = clog2(N);
  localparam int unsigned WX = W + 1;
  localparam logic [WX-1:0] N_EXT = WX'(N);

  logic [W-1:0] ptr;
  logic [W-1:0] eff_ptr;
  logic [N-1:0] rot;
  logic [W-1:0] rot_idx;
  logic [W-1:0] sel_idx;
  logic         hit;
  logic         multi;
  logic         capture;

  // (a + b) mod N for a, b < N; one conditional subtract is enough.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [WX-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_EXT) s = s - N_EXT;
    return s[W-1:0];
  endfunction

  // Fixed mode is round-robin with the pointer forced to zero.
  assign eff_ptr = (mode == MODE_RR) ? ptr : '0;

  // Rotate so the request just below the last winner lands at the top bit.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[add_mod(W'(i), eff_ptr)];
    end
  end

  prio_enc_fixed #(.N(N)) u_fixed (
    .req     (rot),
    .idx_c   (rot_idx),
    .hit_c   (hit),
    .multi_c (multi)
  );

  assign sel_idx = add_mod(rot_idx, eff_ptr);
  assign capture = !out_valid || out_ready;

  // Output registers and pointer; everything holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      ptr        <= '0;
    end else if (capture) begin
      if (hit) begin
        out_valid  <= 1'b1;
        out_idx    <= sel_idx;
        out_onehot <= N'(1) << sel_idx;
        out_multi  <= multi;
        if (mode == MODE_RR) ptr <= sel_idx;
      end else begin
        out_valid  <= 1'b0;
        out_idx    <= '0;
        out_onehot <= '0;
        out_multi  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Self-checking bench for prio_enc_rr: an N=8 and an N=5 instance driven
// side by side, compared against a priority-list reference model.
module tb_prio_enc_rr;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] rdy;
  logic [7:0] req8;
  logic [4:0] req5;

  logic       v8, m8, v5, m5;
  logic [2:0] i8, i5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  prio_enc_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode[0]), .req(req8), .out_ready(rdy[0]),
    .out_valid(v8), .out_idx(i8), .out_onehot(oh8), .out_multi(m8)
  );

  prio_enc_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode[1]), .req(req5), .out_ready(rdy[1]),
    .out_valid(v5), .out_idx(i5), .out_onehot(oh5), .out_multi(m5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state per instance: 0 -> N=8, 1 -> N=5.
  bit mv[2];
  int mi[2];
  bit mm[2];
  int mg[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mi[k] = 0; mm[k] = 0; mg[k] = 0;
    end
  endtask

  // Walk the priority list g-1, g-2, ..., g (mod n); first requester wins.
  task automatic model_edge(input int k, input int n, input logic [63:0] r,
                            input bit md, input bit ready);
    int start;
    int c;
    if (mv[k] && !ready) return;
    if (r == 0) begin
      mv[k] = 0; mi[k] = 0; mm[k] = 0;
      return;
    end
    start = md ? mg[k] : 0;
    for (int kk = 1; kk <= n; kk++) begin
      c = (start - kk + n) % n;
      if (r[c]) begin
        mi[k] = c;
        break;
      end
    end
    mv[k] = 1;
    mm[k] = ($countones(r) > 1);
    if (md) mg[k] = mi[k];
  endtask

  task automatic check_all();
    chk("v8",  64'(v8),  64'(mv[0]));
    chk("i8",  64'(i8),  64'(mi[0]));
    chk("oh8", 64'(oh8), mv[0] ? (64'd1 << mi[0]) : 64'd0);
    chk("m8",  64'(m8),  64'(mm[0]));
    chk("v5",  64'(v5),  64'(mv[1]));
    chk("i5",  64'(i5),  64'(mi[1]));
    chk("oh5", 64'(oh5), mv[1] ? (64'd1 << mi[1]) : 64'd0);
    chk("m5",  64'(m5),  64'(mm[1]));
  endtask

  // One clock edge: advance the model with the held inputs, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(0, 8, 64'(req8), mode[0], rdy[0]);
    model_edge(1, 5, 64'(req5), mode[1], rdy[1]);
    #1;
    check_all();
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  int exp_rr8 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int exp_rr5 [5] = '{4, 1, 0, 4, 1};

  initial begin
    rst = 1'b1; mode = 2'b00; rdy = 2'b11; req8 = '0; req5 = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Fixed mode on the N=8 instance.
    req8 = 8'b1010_0100;
    step();
    chk("fix_idx7", 64'(i8), 64'd7);
    chk("fix_oh80", 64'(oh8), 64'h80);
    chk("fix_multi", 64'(m8), 64'd1);
    req8 = 8'h01;
    step();
    chk("fix_idx0", 64'(i8), 64'd0);
    chk("fix_single", 64'(m8), 64'd0);
    req8 = 8'h00;
    step();
    chk("fix_empty", 64'(v8), 64'd0);

    // Round-robin rotation on N=8 and wrap on N=5.
    mid_reset();
    mode = 2'b11; req8 = 8'hFF; req5 = 5'b10011;
    for (int s = 0; s < 9; s++) begin
      step();
      chk("rr8_seq", 64'(i8), 64'(exp_rr8[s]));
      if (s < 5) chk("rr5_seq", 64'(i5), 64'(exp_rr5[s]));
    end
    mode = 2'b00;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("fix_after_rr", 64'(i8), 64'd7);
    end

    // Single requester: same grant repeatedly in round-robin.
    mode = 2'b11; req8 = 8'h10; req5 = 5'b00100;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("single8", 64'(i8), 64'd4);
      chk("single5", 64'(i5), 64'd2);
    end

    // Backpressure holds outputs and the pointer.
    mid_reset();
    mode = 2'b11; req8 = 8'hFF; req5 = 5'h1F;
    step();
    chk("bp_first", 64'(i8), 64'd7);
    rdy = 2'b00;
    for (int s = 0; s < 3; s++) begin
      req8 = 8'($urandom);
      req5 = 5'($urandom);
      step();
      chk("bp_hold", 64'(i8), 64'd7);
    end
    rdy = 2'b11; req8 = 8'hFF;
    step();
    chk("bp_resume", 64'(i8), 64'd6);

    // Mid-stream reset returns the pointer to zero.
    step();
    chk("pre_rst", 64'(i8), 64'd5);
    mid_reset();
    req8 = 8'hFF;
    step();
    chk("post_rst", 64'(i8), 64'd7);

    // Randomised traffic on both instances.
    for (int s = 0; s < 400; s++) begin
      mode = 2'($urandom);
      rdy[0] = ($urandom_range(0, 3) != 0);
      rdy[1] = ($urandom_range(0, 3) != 0);
      req8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      req5 = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
      if ($urandom_range(0, 59) == 0) mid_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
